burst_read_responder: RTL and testbench
=======================================

# burst_read_responder

Memory-side responder for the burst descriptors produced by the address generation unit. It accepts one burst descriptor at a time, splits it into single-beat reads to a fixed-latency on-chip SRAM, and returns read data beats over a valid/ready stream, flagging the last beat of each burst and of each sequence. It sits between the AGU and the accelerator datapath and applies backpressure so that no read data is ever dropped.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 64, SRAM/response word width; power of two, 8..1024
- OUT_DEPTH, 4, response FIFO entries; must be ≥ 2, and ≥ 3 for one beat per cycle
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- req_valid_i  in  1  descriptor valid
- req_ready_o  out  1  descriptor accepted when high together with req_valid_i
- req_addr_i  in  ADDR_WIDTH  burst start byte address
- req_len_i  in  8  beats − 1
- req_size_i  in  3  log2 bytes per beat
- req_last_i  in  1  final descriptor of the sequence
- mem_req_o  out  1  SRAM read strobe
- mem_addr_o  out  ADDR_WIDTH  SRAM byte address, valid with mem_req_o
- mem_rdata_i  in  DATA_WIDTH  read data, valid exactly one cycle after mem_req_o
- rsp_valid_o  out  1  response beat valid
- rsp_ready_i  in  1  response beat consumed
- rsp_data_o  out  DATA_WIDTH  full SRAM word; the consumer extracts the lane
- rsp_last_o  out  1  last beat of the burst
- rsp_seq_last_o  out  1  last beat of the last burst of the sequence
- rsp_err_o  out  1  beat belongs to a rejected descriptor; data is 0
- busy_o  out  1  descriptor active, read in flight, or FIFO non-empty

## Operation
- States: IDLE, BURST, ERR.
- IDLE: req_ready_o = 1. On a handshake, latch addr, size, and last; set beats_left = len + 1 (9-bit).
  - Go to ERR if req_size_i > log2(DATA_WIDTH/8), or if addr is not aligned to 1 << size.
  - Otherwise go to BURST.
- BURST: assert mem_req_o when fifo_count + inflight < OUT_DEPTH.
  - On each issue:
    - addr += 1 << size, modulo 2^ADDR_WIDTH (wraps silently).
    - beats_left −= 1.
    - Register an in-flight tag {last = (beats_left == 1), seq_last = last && (beats_left == 1)}.
  - On issuing the final beat, go to IDLE.
- Read return: the cycle after an issue, push {mem_rdata_i, tag, err = 0} into the FIFO. The credit check guarantees space.
- ERR: no memory access.
  - Push an error beat {data 0, err 1, same last/seq_last rule} when inflight == 0 and fifo_count < OUT_DEPTH.
  - Decrement beats_left on each push; go to IDLE after the final push.
- FIFO output: rsp_valid_o = fifo_count ≠ 0; the head drives rsp_data_o, rsp_last_o, rsp_seq_last_o, and rsp_err_o. Pop on rsp_valid_o && rsp_ready_i.
  - A push and a pop in the same cycle leave the count unchanged.
  - A pop of a full FIFO in the same cycle as a push is legal.
- The credit check uses fifo_count before any same-cycle pop (conservative). The FIFO never overflows; overflow is a checkable assertion.
- mem_req_o is never asserted in IDLE or ERR.

## Timing
- Reset (rst_i high, asynchronous):
  - State IDLE.
  - FIFO emptied, in-flight tag cleared.
  - mem_req_o, rsp_valid_o, rsp_last_o, rsp_seq_last_o, rsp_err_o, busy_o = 0.
  - mem_addr_o and rsp_data_o = 0.
  - req_ready_o = 1 once in IDLE.
- Reset mid-burst discards the remaining beats, the in-flight read data, and all queued beats; the next descriptor starts clean.
- Descriptor handshake in cycle 0; first mem_req_o in cycle 1; data written at the end of cycle 2; rsp_valid_o in cycle 3. First-beat latency is 3 cycles.
- With rsp_ready_i held high and OUT_DEPTH ≥ 3, the block issues and returns one beat per cycle.
- req_ready_o rises in the cycle after the final issue, so back-to-back descriptors have a 1-cycle issue bubble.
- Response beats keep descriptor order and beat order; the same holds for error beats.
- rsp_* is stable while rsp_valid_o is high and rsp_ready_i is low.

## Test plan
- Descriptor {addr 0x100, len 3, size 3, last 1}, ready held high:
  - mem_addr_o = 0x100, 0x108, 0x110, 0x118 in cycles 1–4.
  - Four beats in cycles 3–6 carrying the SRAM words.
  - rsp_last_o and rsp_seq_last_o high only on the 4th beat.
- Same descriptor with rsp_ready_i low for 10 cycles, then high:
  - mem_req_o stalls after 4 outstanding beats (fifo + inflight = OUT_DEPTH).
  - No beat lost, duplicated, or reordered; 4 beats returned.
- Misaligned descriptor {addr 0x102, len 1, size 2}:
  - mem_req_o stays 0.
  - Two beats with rsp_err_o = 1, data 0, rsp_last_o on the 2nd.
- Oversized descriptor {size 4} with DATA_WIDTH 64: same error behaviour; then a valid descriptor completes normally.
- Two back-to-back descriptors {0x0, len 1, size 3, last 0} and {0x40, len 0, size 3, last 1}:
  - Beats at 0x0, 0x8, 0x40.
  - rsp_last_o on beats 2 and 3; rsp_seq_last_o only on beat 3.
- rsp_ready_i random, and rst_i asserted after 2 of 8 beats have issued:
  - All outputs return to reset values in the same cycle; busy_o = 0.
  - A following descriptor {0x200, len 0, size 3} returns exactly one beat.

Source files
------------

// File: rtl/burst_read_responder.sv
// Burst read responder: splits AGU burst descriptors into single-beat SRAM reads
// and returns the words over a valid/ready stream with burst/sequence-last flags.
module burst_read_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int OUT_DEPTH  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [7:0]            req_len_i,
  input  logic [2:0]            req_size_i,
  input  logic                  req_last_i,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  rsp_last_o,
  output logic                  rsp_seq_last_o,
  output logic                  rsp_err_o,
  output logic                  busy_o
);

  localparam int LANE_LOG = $clog2(DATA_WIDTH / 8);
  localparam int CNT_W    = $clog2(OUT_DEPTH + 1);
  localparam int PTR_W    = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BURST,
    S_ERR
  } state_t;

  state_t                r_state, w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_next;
  logic [2:0]            r_size, w_size_next;
  logic                  r_last, w_last_next;
  logic [8:0]            r_beats_left, w_beats_left_next;

  logic                  r_inf_vld;
  logic                  r_inf_last;
  logic                  r_inf_seq_last;

  logic [DATA_WIDTH-1:0] r_fifo_data [OUT_DEPTH];
  logic [OUT_DEPTH-1:0]  r_fifo_last;
  logic [OUT_DEPTH-1:0]  r_fifo_seq_last;
  logic [OUT_DEPTH-1:0]  r_fifo_err;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  logic                  w_req_fire;
  logic                  w_req_bad;
  logic [ADDR_WIDTH-1:0] w_align_mask;
  logic [ADDR_WIDTH-1:0] w_stride;
  logic                  w_final_beat;
  logic                  w_tag_last;
  logic                  w_tag_seq_last;
  logic                  w_credit_ok;
  logic                  w_issue;
  logic                  w_err_push;
  logic                  w_push;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_push_data;
  logic                  w_push_last;
  logic                  w_push_seq_last;
  logic                  w_push_err;
  logic                  w_head_vld;
  logic [PTR_W-1:0]      w_wr_ptr_inc;
  logic [PTR_W-1:0]      w_rd_ptr_inc;

  assign w_req_fire   = (r_state == S_IDLE) && req_valid_i;
  assign w_align_mask = (ADDR_WIDTH'(1) << req_size_i) - ADDR_WIDTH'(1);
  assign w_req_bad    = (req_size_i > 3'(LANE_LOG)) || ((req_addr_i & w_align_mask) != '0);
  assign w_stride     = ADDR_WIDTH'(1) << r_size;

  assign w_final_beat   = (r_beats_left == 9'd1);
  assign w_tag_last     = w_final_beat;
  assign w_tag_seq_last = r_last && w_final_beat;

  // Credit uses the pre-pop count so a pending read always has a free slot.
  assign w_credit_ok = ({1'b0, r_count} + (CNT_W + 1)'(r_inf_vld)) < (CNT_W + 1)'(OUT_DEPTH);
  assign w_issue     = (r_state == S_BURST) && w_credit_ok;
  assign w_err_push  = (r_state == S_ERR) && !r_inf_vld && (r_count < CNT_W'(OUT_DEPTH));

  assign w_push          = r_inf_vld || w_err_push;
  assign w_head_vld      = (r_count != '0);
  assign w_pop           = w_head_vld && rsp_ready_i;
  assign w_push_data     = r_inf_vld ? mem_rdata_i : '0;
  assign w_push_last     = r_inf_vld ? r_inf_last : w_tag_last;
  assign w_push_seq_last = r_inf_vld ? r_inf_seq_last : w_tag_seq_last;
  assign w_push_err      = !r_inf_vld;

  assign w_wr_ptr_inc = (r_wr_ptr == PTR_W'(OUT_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
  assign w_rd_ptr_inc = (r_rd_ptr == PTR_W'(OUT_DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);

  always_comb begin
    w_state_next      = r_state;
    w_addr_next       = r_addr;
    w_size_next       = r_size;
    w_last_next       = r_last;
    w_beats_left_next = r_beats_left;
    case (r_state)
      S_IDLE: begin
        if (w_req_fire) begin
          w_addr_next       = req_addr_i;
          w_size_next       = req_size_i;
          w_last_next       = req_last_i;
          w_beats_left_next = {1'b0, req_len_i} + 9'd1;
          w_state_next      = w_req_bad ? S_ERR : S_BURST;
        end
      end
      S_BURST: begin
        if (w_issue) begin
          w_addr_next       = r_addr + w_stride;
          w_beats_left_next = r_beats_left - 9'd1;
          if (w_final_beat) begin
            w_state_next = S_IDLE;
          end
        end
      end
      S_ERR: begin
        if (w_err_push) begin
          w_beats_left_next = r_beats_left - 9'd1;
          if (w_final_beat) begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state        <= S_IDLE;
      r_addr         <= '0;
      r_size         <= '0;
      r_last         <= 1'b0;
      r_beats_left   <= '0;
      r_inf_vld      <= 1'b0;
      r_inf_last     <= 1'b0;
      r_inf_seq_last <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_addr         <= w_addr_next;
      r_size         <= w_size_next;
      r_last         <= w_last_next;
      r_beats_left   <= w_beats_left_next;
      r_inf_vld      <= w_issue;
      r_inf_last     <= w_issue && w_tag_last;
      r_inf_seq_last <= w_issue && w_tag_seq_last;
    end
  end

  // Data storage carries no reset; occupancy is tracked by the reset pointers.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= w_push_data;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_fifo_last     <= '0;
      r_fifo_seq_last <= '0;
      r_fifo_err      <= '0;
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
    end else begin
      if (w_push) begin
        r_fifo_last[r_wr_ptr]     <= w_push_last;
        r_fifo_seq_last[r_wr_ptr] <= w_push_seq_last;
        r_fifo_err[r_wr_ptr]      <= w_push_err;
        r_wr_ptr                  <= w_wr_ptr_inc;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_inc;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  assert property (@(posedge clk_i) disable iff (rst_i)
    !(w_push && !w_pop && (r_count == CNT_W'(OUT_DEPTH))));

  assign req_ready_o    = (r_state == S_IDLE);
  assign mem_req_o      = w_issue;
  assign mem_addr_o     = r_addr;
  assign rsp_valid_o    = w_head_vld;
  assign rsp_data_o     = w_head_vld ? r_fifo_data[r_rd_ptr] : '0;
  assign rsp_last_o     = w_head_vld && r_fifo_last[r_rd_ptr];
  assign rsp_seq_last_o = w_head_vld && r_fifo_seq_last[r_rd_ptr];
  assign rsp_err_o      = w_head_vld && r_fifo_err[r_rd_ptr];
  assign busy_o         = (r_state != S_IDLE) || r_inf_vld || w_head_vld;

endmodule

// File: tb/tb_burst_read_responder.sv
// Directed plus randomized bench for burst_read_responder, checked against a
// descriptor-level model that expands each burst into its expected beats.
module tb_burst_read_responder;

  localparam int AW    = 32;
  localparam int DW    = 64;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [AW-1:0] req_addr_i;
  logic [7:0]    req_len_i;
  logic [2:0]    req_size_i;
  logic          req_last_i;
  logic          mem_req_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_rdata_i = '0;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [DW-1:0] rsp_data_o;
  logic          rsp_last_o;
  logic          rsp_seq_last_o;
  logic          rsp_err_o;
  logic          busy_o;

  burst_read_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_DEPTH(DEPTH)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_addr_i    (req_addr_i),
    .req_len_i     (req_len_i),
    .req_size_i    (req_size_i),
    .req_last_i    (req_last_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_rdata_i   (mem_rdata_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_data_o    (rsp_data_o),
    .rsp_last_o    (rsp_last_o),
    .rsp_seq_last_o(rsp_seq_last_o),
    .rsp_err_o     (rsp_err_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] sram_word(input logic [AW-1:0] a);
    return {a ^ 32'h5A5A_C3C3, ~a};
  endfunction

  // One-cycle-latency SRAM; garbage on the data bus when no read was issued.
  always @(posedge clk) begin
    if (mem_req_o) mem_rdata_i <= sram_word(mem_addr_o);
    else           mem_rdata_i <= {$urandom, $urandom};
  end

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic          seq_last;
    logic          err;
  } beat_t;

  beat_t         exp_q[$];
  logic [AW-1:0] addr_q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_issue = 0;
  int n_beats = 0;
  int hs_cyc = 0;
  int first_req_cyc = -1;
  int first_rsp_cyc = -1;
  int last_rsp_cyc = -1;
  int rdy_mode = 0;
  logic          prev_valid = 1'b0;
  logic          prev_ready = 1'b0;
  logic [DW+3:0] prev_bundle = '0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expand a descriptor into expected memory addresses and response beats.
  task automatic model_accept(input logic [AW-1:0] addr, input int len, input int size,
                              input logic last);
    int   n;
    int   bytes;
    logic bad;
    logic [AW-1:0] a;
    beat_t b;
    n     = len + 1;
    bytes = 1 << size;
    bad   = (bytes > DW / 8) || ((addr % bytes) != 0);
    for (int i = 0; i < n; i++) begin
      a = addr + AW'(i * bytes);
      b.last     = (i == n - 1);
      b.seq_last = last && (i == n - 1);
      b.err      = bad;
      if (bad) begin
        b.data = '0;
      end else begin
        b.data = sram_word(a);
        addr_q.push_back(a);
      end
      exp_q.push_back(b);
    end
  endtask

  task automatic monitor();
    beat_t e;
    logic [DW+3:0] bundle;
    bundle = {rsp_valid_o, rsp_data_o, rsp_last_o, rsp_seq_last_o, rsp_err_o};
    if (mem_req_o) begin
      n_issue++;
      if (first_req_cyc < 0) first_req_cyc = cyc;
      if (addr_q.size() == 0) check("mem_req_unexpected", 1, 0);
      else                    check("mem_addr", mem_addr_o, addr_q.pop_front());
    end
    if (prev_valid && !prev_ready) check("rsp_stable", bundle, prev_bundle);
    if (rsp_valid_o && first_rsp_cyc < 0) first_rsp_cyc = cyc;
    if (rsp_valid_o && rsp_ready_i) begin
      n_beats++;
      last_rsp_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_beat", {rsp_data_o, rsp_last_o, rsp_seq_last_o, rsp_err_o}, e);
      end
    end
    prev_valid  = rsp_valid_o;
    prev_ready  = rsp_ready_i;
    prev_bundle = bundle;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    case (rdy_mode)
      0:       rsp_ready_i = 1'b1;
      1:       rsp_ready_i = 1'b0;
      default: rsp_ready_i = 1'($urandom_range(0, 1));
    endcase
    monitor();
  endtask

  task automatic send(input logic [AW-1:0] addr, input int len, input int size, input logic last);
    int k;
    k = 0;
    while (!req_ready_o && k < 200) begin
      tick();
      k++;
    end
    if (!req_ready_o) begin
      check("req_ready_timeout", 0, 1);
    end else begin
      req_valid_i = 1'b1;
      req_addr_i  = addr;
      req_len_i   = 8'(len);
      req_size_i  = 3'(size);
      req_last_i  = last;
      hs_cyc      = cyc;
      model_accept(addr, len, size, last);
      tick();
      req_valid_i = 1'b0;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy_o) && k < 400) begin
      tick();
      k++;
    end
    check("drain_timeout", 1'(k < 400), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, {mem_req_o, rsp_valid_o, rsp_last_o, rsp_seq_last_o, rsp_err_o, busy_o,
                mem_addr_o, rsp_data_o, req_ready_o}, {6'b0, 32'b0, 64'b0, 1'b1});
  endtask

  initial begin
    int n0;
    int b0;
    int hs1;
    int k;
    int sz;
    logic [AW-1:0] a;

    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    req_addr_i  = '0;
    req_len_i   = '0;
    req_size_i  = '0;
    req_last_i  = 1'b0;
    rsp_ready_i = 1'b1;
    #2;
    check_reset_outputs("reset_state");
    repeat (3) @(posedge clk);
    #3 rst_i = 1'b0;
    tick();

    // Single burst with ready high: latency and streaming rate.
    rdy_mode = 0;
    first_req_cyc = -1;
    first_rsp_cyc = -1;
    b0 = n_beats;
    send(32'h100, 3, 3, 1'b1);
    drain();
    check("first_req_latency", first_req_cyc - hs_cyc, 1);
    check("first_rsp_latency", first_rsp_cyc - hs_cyc, 3);
    check("last_rsp_cycle", last_rsp_cyc - hs_cyc, 6);
    check("burst_beats", n_beats - b0, 4);

    // Held-off consumer: issue must stop once OUT_DEPTH beats are outstanding.
    rdy_mode = 1;
    n0 = n_issue;
    b0 = n_beats;
    send(32'h1000, 7, 3, 1'b0);
    repeat (9) tick();
    check("stall_issue_count", n_issue - n0, DEPTH);
    check("stall_rsp_valid", rsp_valid_o, 1);
    rdy_mode = 0;
    drain();
    check("stall_beats", n_beats - b0, 8);

    // Misaligned descriptor.
    n0 = n_issue;
    b0 = n_beats;
    send(32'h102, 1, 2, 1'b1);
    drain();
    check("misaligned_no_mem", n_issue - n0, 0);
    check("misaligned_beats", n_beats - b0, 2);

    // Oversized beat, then a normal burst.
    n0 = n_issue;
    b0 = n_beats;
    send(32'h100, 2, 4, 1'b1);
    drain();
    check("oversize_no_mem", n_issue - n0, 0);
    check("oversize_beats", n_beats - b0, 3);
    send(32'h2000, 1, 3, 1'b1);
    drain();
    check("after_err_beats", n_beats - b0, 5);

    // Back-to-back descriptors with a one-cycle issue bubble.
    b0 = n_beats;
    send(32'h0, 1, 3, 1'b0);
    hs1 = hs_cyc;
    send(32'h40, 0, 3, 1'b1);
    check("b2b_handshake_gap", hs_cyc - hs1, 3);
    drain();
    check("b2b_beats", n_beats - b0, 3);

    // Address wrap at the top of the address space.
    send(32'hFFFF_FFF8, 2, 3, 1'b1);
    drain();

    // Reset in the middle of a burst with a random consumer.
    rdy_mode = 2;
    n0 = n_issue;
    send(32'h300, 7, 3, 1'b1);
    k = 0;
    while (n_issue - n0 < 2 && k < 100) begin
      tick();
      k++;
    end
    check("pre_reset_issue", 1'(n_issue - n0 >= 2), 1);
    @(posedge clk);
    #2 rst_i = 1'b1;
    #1;
    check_reset_outputs("mid_burst_reset");
    exp_q.delete();
    addr_q.delete();
    prev_valid = 1'b0;
    @(posedge clk);
    #2 rst_i = 1'b0;
    tick();
    rdy_mode = 0;
    b0 = n_beats;
    send(32'h200, 0, 3, 1'b1);
    drain();
    check("post_reset_beats", n_beats - b0, 1);

    // Randomized descriptors against a random consumer.
    rdy_mode = 2;
    for (int t = 0; t < 30; t++) begin
      sz = $urandom_range(0, 4);
      a  = $urandom;
      a  = a & ~((AW'(1) << sz) - AW'(1));
      if ($urandom_range(0, 7) == 0) a = a | AW'(1);
      send(a, $urandom_range(0, 6), sz, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) drain();
    end
    drain();
    check("final_queue_empty", exp_q.size() + addr_q.size(), 0);
    check("final_idle", {busy_o, req_ready_o}, 2'b01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
